mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the two-port memory arbiter.
// master: requesters plus memory model; slave: the arbiter.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_wen;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      mem_en;
  logic                      mem_wen;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport master (
    output req_valid, req_wen, req_addr,
    output req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester single-port memory arbiter, IDLE/ACCESS/RESP FSM.
// MEM_PORT_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t             state;
  logic               owner;
  logic               wen_q;
  logic               sel;
  logic               hit;
  logic               grant;
  logic               g_wen;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic [NUM_REQ-1:0] owner_oh;
  logic               unused_bits;

`ifdef MEM_PORT_ARB_RR_EN
  logic rr_ptr;
`endif

  // Pick the winner among the valid requesters.
  always_comb begin
    hit = |bus.req_valid;
`ifdef MEM_PORT_ARB_RR_EN
    sel = bus.req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
`else
    sel = bus.req_valid[0] ? 1'b0 : 1'b1;
`endif
  end

  assign grant = (state == IDLE) && hit && !reset;

  assign g_wen = bus.req_wen[sel];

  assign g_addr = sel
    ? bus.req_addr[2*ADDR_W-1:ADDR_W]
    : bus.req_addr[ADDR_W-1:0];

  assign g_wdata = sel
    ? bus.req_wdata[2*DATA_W-1:DATA_W]
    : bus.req_wdata[DATA_W-1:0];

  // Memory is word-addressed; byte offset is dropped.
  assign unused_bits = ^g_addr[2:0];

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[sel] = 1'b1;
  end

  always_comb begin
    owner_oh = '0;
    owner_oh[owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= 1'b0;
      wen_q          <= 1'b0;
      bus.mem_en     <= 1'b0;
      bus.mem_wen    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;
`ifdef MEM_PORT_ARB_RR_EN
      rr_ptr         <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            state         <= ACCESS;
            owner         <= sel;
            wen_q         <= g_wen;
            bus.mem_en    <= ~g_wen;
            bus.mem_wen   <= g_wen;
            bus.mem_addr  <= {g_addr[ADDR_W-1:3],
                              3'b000};
            bus.mem_wdata <= g_wdata;
`ifdef MEM_PORT_ARB_RR_EN
            rr_ptr        <= ~sel;
`endif
          end
        end
        ACCESS: begin
          state          <= RESP;
          bus.mem_en     <= 1'b0;
          bus.mem_wen    <= 1'b0;
          bus.resp_valid <= owner_oh;
          bus.resp_rdata <= wen_q ? '0
                                  : bus.mem_rdata;
        end
        RESP: begin
          if (bus.resp_ready[owner]) begin
            state          <= IDLE;
            bus.resp_valid <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table with a
// response scoreboard plus stall, contention and reset sequences.
module tb_mem_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int NVEC    = 10;

  typedef struct {
    logic        id;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] maddr;
    logic [63:0] rdata;
  } vec_t;

  typedef struct {
    logic        id;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vt[NVEC];
  bit [63:0] mem [0:31];

  mem_port_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) bus ();

  mem_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[7:3]];

  always @(posedge clk)
    if (bus.mem_wen) mem[bus.mem_addr[7:3]] <= bus.mem_wdata;

  function automatic logic [1:0] oh(logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid  = '0;
    bus.req_wen    = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 2'b11;
  endtask

  task automatic drive(logic id, logic wen, logic [63:0] addr,
                       logic [63:0] wdata);
    int k;
    k = id ? 1 : 0;
    bus.req_valid = '0;
    bus.req_valid[k] = 1'b1;
    bus.req_wen[k] = wen;
    bus.req_addr[k*ADDR_W +: ADDR_W] = addr;
    bus.req_wdata[k*DATA_W +: DATA_W] = wdata;
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_mem_en"}, bus.mem_en, 0);
    check({tag, "_mem_wen"}, bus.mem_wen, 0);
  endtask

  task automatic run_txn(vec_t v);
    exp_t e;
    int   n;
    e.id = v.id;
    e.rdata = v.rdata;
    sb.push_back(e);
    @(negedge clk);
    drive(v.id, v.wen, v.addr, v.wdata);
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant", bus.req_ready, oh(v.id));
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("mem_en", bus.mem_en, !v.wen);
    check("mem_wen", bus.mem_wen, v.wen);
    check("mem_addr", bus.mem_addr, v.maddr);
    if (v.wen) check("mem_wdata", bus.mem_wdata, v.wdata);
    check("access_ready", bus.req_ready, 0);
    @(negedge clk);
    #1;
    e = sb.pop_front();
    check("resp_valid", bus.resp_valid, oh(e.id));
    check("resp_rdata", bus.resp_rdata, e.rdata);
    check("resp_mem_en", bus.mem_en | bus.mem_wen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [1:0]  exp_g;
    logic [63:0] held;
    int          gap;
    exp_t        e;

    vt[0] = '{1'b0, 1'b1, 64'h8, 64'hDEA, 64'h8, 64'h0};
    vt[1] = '{1'b0, 1'b0, 64'h8, 64'h0, 64'h8, 64'hDEA};
    vt[2] = '{1'b1, 1'b1, 64'h13, 64'h1234_5678, 64'h10, 64'h0};
    vt[3] = '{1'b1, 1'b0, 64'h10, 64'h0, 64'h10, 64'h1234_5678};
    vt[4] = '{1'b0, 1'b0, 64'hD, 64'h0, 64'h8, 64'hDEA};
    vt[5] = '{1'b1, 1'b1, 64'h20, '1, 64'h20, 64'h0};
    vt[6] = '{1'b0, 1'b0, 64'h27, 64'h0, 64'h20, '1};
    vt[7] = '{1'b1, 1'b0, 64'h30, 64'h0, 64'h30, 64'h0};
    vt[8] = '{1'b0, 1'b1, 64'hF000_0000_0000_001F, 64'hA5A5,
              64'hF000_0000_0000_0018, 64'h0};
    vt[9] = '{1'b1, 1'b0, 64'h18, 64'h0, 64'h18, 64'hA5A5};

    idle_inputs();
    @(negedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_wen", bus.mem_wen, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b0;

    repeat (3) begin
      @(negedge clk);
      #1;
      check_quiet("idle");
      check("idle_resp_valid", bus.resp_valid, 0);
    end

    for (int i = 0; i < NVEC; i++) run_txn(vt[i]);

    // Stalled response with contention and a wrong-owner ready.
    @(negedge clk);
    bus.resp_ready = 2'b00;
    drive(1'b0, 1'b0, 64'h8, 64'h0);
    e.id = 1'b0;
    e.rdata = 64'hDEA;
    sb.push_back(e);
    #1;
    check("stall_grant", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_wen = 2'b00;
    bus.req_addr[ADDR_W +: ADDR_W] = 64'h10;
    #1;
    check("stall_access_ready", bus.req_ready, 0);
    @(negedge clk);
    #1;
    e = sb.pop_front();
    check("stall_resp_valid", bus.resp_valid, oh(e.id));
    check("stall_resp_rdata", bus.resp_rdata, e.rdata);
    held = bus.resp_rdata;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("stall_hold_valid", bus.resp_valid, 2'b01);
      check("stall_hold_rdata", bus.resp_rdata, held);
      check_quiet("stall");
    end
    bus.resp_ready = 2'b10;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("wrong_owner_valid", bus.resp_valid, 2'b01);
      check_quiet("wrong_owner");
    end
    bus.req_valid = '0;
    bus.resp_ready = 2'b01;
    @(negedge clk);
    #1;
    check("stall_release_valid", bus.resp_valid, 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check_quiet("post_release");
      check("post_release_valid", bus.resp_valid, 0);
    end

    // Both requesters valid at every IDLE, from a fresh reset.
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_addr = {64'h10, 64'h8};
    #1;
    for (int g = 0; g < 4; g++) begin
      gap = 0;
      if (g > 0) begin
        @(negedge clk);
        #1;
        gap = 1;
      end
      while (bus.req_ready == '0 && gap < 10) begin
        @(negedge clk);
        #1;
        gap++;
      end
`ifdef MEM_PORT_ARB_RR_EN
      exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      check("contend_grant", bus.req_ready, exp_g);
      if (g > 0) check("issue_gap", gap, 3);
    end
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // Reset while requester 1 holds a pending response.
    bus.resp_ready = 2'b00;
    drive(1'b1, 1'b0, 64'h10, 64'h0);
    #1;
    check("rr_grant1", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    check("pre_reset_valid", bus.resp_valid, 2'b10);
    check("pre_reset_rdata", bus.resp_rdata, 64'h1234_5678);
    reset = 1'b1;
    #1;
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    check("mid_rst_resp_rdata", bus.resp_rdata, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_mem_wdata", bus.mem_wdata, 0);
    check_quiet("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    bus.resp_ready = 2'b11;
    #1;
    check("post_rst_valid", bus.resp_valid, 0);
    run_txn(vt[1]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
